// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    // Flush sequencer states.
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of the round-robin pointer / winner index (never below 1 bit).
    function automatic int ptr_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Width of the clear counter, which holds values 0 .. cycles-1.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side and FIFO-side signals of the write arbiter.
// slave is the arbiter's view; master is the view of whatever drives it.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] wr_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          flush_req;
    logic                          flush_done;
    logic                          busy;
    logic                          fifo_full;
    logic                          fifo_write;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_clear;

    modport slave (
        input  req, wr_data, flush_req, fifo_full,
        output gnt, flush_done, busy, fifo_write, fifo_data_in, fifo_clear
    );

    modport master (
        output req, wr_data, flush_req, fifo_full,
        input  gnt, flush_done, busy, fifo_write, fifo_data_in, fifo_clear
    );
endinterface

// File: rtl/rr_pick.sv
// Rotating priority encoder: the first asserted request at or after ptr
// (wrapping at NUM_REQ-1) wins. Purely combinational.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [PTR_W-1:0]   idx
);

    // Scan from the farthest offset down so the nearest request to ptr is the last written.
    always_comb begin
        logic [PTR_W-1:0] pos;
        pos    = '0;
        onehot = '0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (req[pos]) begin
                onehot      = '0;
                onehot[pos] = 1'b1;
                idx         = pos;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin sharing of a single FIFO write port among NUM_REQ producers,
// plus a flush sequencer (block writers, pulse clear, report completion).
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int CLEAR_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    fifo_write_arbiter_if.slave  bus
);

    localparam int               PTR_W    = ptr_width(NUM_REQ);
    localparam int               CNT_W    = cnt_width(CLEAR_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     clr_cnt_q, clr_cnt_d;

    logic                 arb_en;
    logic                 grant_any;
    logic [NUM_REQ-1:0]   pick_req;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [PTR_W-1:0]     pick_idx;
    logic [DATA_WIDTH-1:0] words [NUM_REQ];

    // Arbitration only runs in ARB with no flush pending, room in the FIFO and reset released.
    assign arb_en    = !reset && (state_q == ARB) && !bus.flush_req && !bus.fifo_full;
    assign pick_req  = arb_en ? bus.req : '0;
    assign grant_any = |pick_onehot;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (pick_req),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // Unpack the producer words so the data mux can index by winner.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Zero-latency grant path; data bus is forced to zero when nobody is granted.
    always_comb begin
        bus.gnt          = pick_onehot;
        bus.fifo_write   = grant_any;
        bus.fifo_data_in = '0;
        if (grant_any) begin
            bus.fifo_data_in = words[pick_idx];
        end
    end

    // Next-state logic for the flush sequencer, pointer and clear counter; status outputs decode the registered state.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        clr_cnt_d       = clr_cnt_q;
        bus.fifo_clear  = 1'b0;
        bus.busy        = 1'b0;
        bus.flush_done  = 1'b0;
        case (state_q)
            ARB: begin
                if (bus.flush_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = CNT_LOAD;
                end else if (grant_any) begin
                    rr_ptr_d = (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
                end
            end
            CLEAR: begin
                bus.fifo_clear = 1'b1;
                bus.busy       = 1'b1;
                if (clr_cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    clr_cnt_d = clr_cnt_q - 1'b1;
                end
            end
            DONE: begin
                bus.flush_done = 1'b1;
                bus.busy       = 1'b1;
                rr_ptr_d       = '0;
                state_d        = ARB;
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // State, pointer and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ARB;
            rr_ptr_q  <= '0;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: one instance with a single
// clear cycle (dut_a, feeding a FIFO model) and one with three (dut_b).
module tb_fifo_write_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] fifo_q [$];
    logic [31:0] exp_q  [$];
    logic [31:0] words  [4] = '{32'd100, 32'd150, 32'd200, 32'd40};

    fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) ifa ();
    fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) ifb ();

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .CLEAR_CYCLES(1)) dut_a (
        .clock (clk),
        .reset (rst),
        .bus   (ifa)
    );

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .CLEAR_CYCLES(3)) dut_b (
        .clock (clk),
        .reset (rst),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    // FIFO model behind dut_a: synchronous clear, otherwise store on write.
    always @(posedge clk) begin
        if (ifa.fifo_clear) fifo_q.delete();
        else if (ifa.fifo_write) fifo_q.push_back(ifa.fifo_data_in);
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic flush_pulse_a();
        @(negedge clk); ifa.flush_req = 1'b1;
        @(negedge clk); ifa.flush_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_tests++; if (ifa.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", ifa.gnt); end
            n_tests++; if (ifa.fifo_write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b want 0", ifa.fifo_write); end
            n_tests++; if (ifa.fifo_clear !== 1'b0) begin n_fail++; $display("FAIL reset_clear: got %b want 0", ifa.fifo_clear); end
        end
        rst = 1'b0; #1;
        n_tests++; if (ifa.gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt: got %b want 0001", ifa.gnt); end
        n_tests++; if (ifa.fifo_data_in !== 32'd100) begin n_fail++; $display("FAIL reset_first_data: got %0d want 100", ifa.fifo_data_in); end
        n_tests++; if (ifa.busy !== 1'b0 || ifa.flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_status: busy %b done %b want 0 0", ifa.busy, ifa.flush_done); end
        ifa.req = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        exp_q.delete();
        @(negedge clk);
        ifa.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            eg = 4'b0001 << (i % 4);
            n_tests++; if (ifa.gnt !== eg) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, ifa.gnt, eg); end
            n_tests++; if (ifa.fifo_data_in !== words[i%4]) begin n_fail++; $display("FAIL rr_data[%0d]: got %0d want %0d", i, ifa.fifo_data_in, words[i%4]); end
            exp_q.push_back(words[i%4]);
            @(negedge clk);
        end
        ifa.req = 4'b0000;
        n_tests++; if (fifo_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rr_fifo_count: got %0d want %0d", fifo_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && fifo_q.size() > 0) begin
            n_tests++; if (fifo_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL rr_fifo_word: got %0d want %0d", fifo_q[0], exp_q[0]); end
            void'(fifo_q.pop_front());
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_fifo_full();
        flush_pulse_a();
        exp_q.delete();
        ifa.req       = 4'b0101;
        ifa.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (ifa.gnt !== 4'b0000) begin n_fail++; $display("FAIL full_gnt[%0d]: got %b want 0000", i, ifa.gnt); end
            n_tests++; if (ifa.fifo_write !== 1'b0) begin n_fail++; $display("FAIL full_write[%0d]: got %b want 0", i, ifa.fifo_write); end
            @(negedge clk);
        end
        ifa.fifo_full = 1'b0; #1;
        n_tests++; if (ifa.gnt !== 4'b0001) begin n_fail++; $display("FAIL full_resume_gnt0: got %b want 0001", ifa.gnt); end
        exp_q.push_back(32'd100);
        @(negedge clk); #1;
        n_tests++; if (ifa.gnt !== 4'b0100) begin n_fail++; $display("FAIL full_resume_gnt2: got %b want 0100", ifa.gnt); end
        n_tests++; if (ifa.fifo_data_in !== 32'd200) begin n_fail++; $display("FAIL full_resume_data: got %0d want 200", ifa.fifo_data_in); end
        exp_q.push_back(32'd200);
        @(negedge clk);
        ifa.req = 4'b0000;
        n_tests++; if (fifo_q.size() != exp_q.size()) begin n_fail++; $display("FAIL full_fifo_count: got %0d want %0d", fifo_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < fifo_q.size(); i++) begin
            n_tests++; if (fifo_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_fifo_word[%0d]: got %0d want %0d", i, fifo_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        ifa.req       = 4'b0010;
        ifa.flush_req = 1'b1; #1;
        n_tests++; if (ifa.gnt !== 4'b0000 || ifa.fifo_write !== 1'b0) begin n_fail++; $display("FAIL flush_prio: gnt %b write %b want 0000 0", ifa.gnt, ifa.fifo_write); end
        @(negedge clk);
        ifa.flush_req = 1'b0;
        for (int c = 0; c < 1; c++) begin
            #1;
            n_tests++; if (ifa.fifo_clear !== 1'b1 || ifa.busy !== 1'b1 || ifa.gnt !== 4'b0000) begin n_fail++; $display("FAIL flush_clear: clear %b busy %b gnt %b want 1 1 0000", ifa.fifo_clear, ifa.busy, ifa.gnt); end
            @(negedge clk);
        end
        #1;
        n_tests++; if (ifa.fifo_clear !== 1'b0 || ifa.flush_done !== 1'b1 || ifa.busy !== 1'b1 || ifa.gnt !== 4'b0000) begin n_fail++; $display("FAIL flush_done: clear %b done %b busy %b gnt %b want 0 1 1 0000", ifa.fifo_clear, ifa.flush_done, ifa.busy, ifa.gnt); end
        n_tests++; if (fifo_q.size() != 0) begin n_fail++; $display("FAIL flush_empty: got %0d entries want 0", fifo_q.size()); end
        @(negedge clk); #1;
        n_tests++; if (ifa.gnt !== 4'b0010 || ifa.flush_done !== 1'b0 || ifa.busy !== 1'b0) begin n_fail++; $display("FAIL flush_resume: gnt %b done %b busy %b want 0010 0 0", ifa.gnt, ifa.flush_done, ifa.busy); end
        @(negedge clk);
        ifa.req = 4'b0000;
        n_tests++; if (fifo_q.size() != 1) begin n_fail++; $display("FAIL flush_after_count: got %0d want 1", fifo_q.size()); end
        else begin
            n_tests++; if (fifo_q[0] !== 32'd150) begin n_fail++; $display("FAIL flush_after_word: got %0d want 150", fifo_q[0]); end
        end
    endtask

    task automatic test_flush_long();
        int nclr  = 0;
        int ndone = 0;
        int nbad  = 0;
        @(negedge clk);
        ifb.req       = 4'b1111;
        ifb.flush_req = 1'b1; #1;
        n_tests++; if (ifb.gnt !== 4'b0000) begin n_fail++; $display("FAIL long_prio: got %b want 0000", ifb.gnt); end
        @(negedge clk);
        ifb.flush_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (ifb.fifo_clear === 1'b1) nclr++;
            if (ifb.flush_done === 1'b1) ndone++;
            if (ifb.busy === 1'b1 && ifb.gnt !== 4'b0000) nbad++;
            if (k == 4) begin
                n_tests++; if (ifb.gnt !== 4'b0001) begin n_fail++; $display("FAIL long_resume_gnt: got %b want 0001", ifb.gnt); end
            end
            if (k == 0) ifb.flush_req = 1'b1;
            if (k == 1) ifb.flush_req = 1'b0;
            @(negedge clk);
        end
        ifb.req = 4'b0000;
        n_tests++; if (nclr != 3) begin n_fail++; $display("FAIL long_clear_cycles: got %0d want 3", nclr); end
        n_tests++; if (ndone != 1) begin n_fail++; $display("FAIL long_done_pulses: got %0d want 1", ndone); end
        n_tests++; if (nbad != 0) begin n_fail++; $display("FAIL long_gnt_while_busy: got %0d cycles want 0", nbad); end
    endtask

    task automatic test_reset_mid_flush();
        int ndone = 0;
        @(negedge clk);
        ifb.req = 4'b0010; #1;
        n_tests++; if (ifb.gnt !== 4'b0010) begin n_fail++; $display("FAIL midrst_pre_gnt: got %b want 0010", ifb.gnt); end
        @(negedge clk);
        ifb.req       = 4'b0000;
        ifb.flush_req = 1'b1;
        @(negedge clk);
        ifb.flush_req = 1'b0; #1;
        n_tests++; if (ifb.fifo_clear !== 1'b1) begin n_fail++; $display("FAIL midrst_in_clear: got %b want 1", ifb.fifo_clear); end
        rst = 1'b1;
        @(negedge clk); #1;
        n_tests++; if (ifb.fifo_clear !== 1'b0 || ifb.busy !== 1'b0 || ifb.flush_done !== 1'b0) begin n_fail++; $display("FAIL midrst_status: clear %b busy %b done %b want 0 0 0", ifb.fifo_clear, ifb.busy, ifb.flush_done); end
        rst     = 1'b0;
        ifb.req = 4'b1111; #1;
        n_tests++; if (ifb.gnt !== 4'b0001) begin n_fail++; $display("FAIL midrst_ptr: got %b want 0001", ifb.gnt); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (ifb.flush_done === 1'b1) ndone++;
        end
        ifb.req = 4'b0000;
        n_tests++; if (ndone != 0) begin n_fail++; $display("FAIL midrst_done: got %0d pulses want 0", ndone); end
    endtask

    initial begin
        rst           = 1'b1;
        ifa.req       = 4'b1111;
        ifa.wr_data   = {32'd40, 32'd200, 32'd150, 32'd100};
        ifa.flush_req = 1'b0;
        ifa.fifo_full = 1'b0;
        ifb.req       = 4'b0000;
        ifb.wr_data   = {32'd40, 32'd200, 32'd150, 32'd100};
        ifb.flush_req = 1'b0;
        ifb.fifo_full = 1'b0;

        test_reset();
        test_round_robin();
        test_fifo_full();
        test_flush();
        test_flush_long();
        test_reset_mid_flush();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
